prefetch_rob_mc: RTL and testbench

- Parametrised multi-channel prefetch reorder buffer for the CNN AFU read path.
- Issues a burst of cache-line read requests from a base address and tags each request with its sequence index.
- Accepts out-of-order read responses into a ROB and delivers lines strictly in order on a valid/ready stream, steered to one of NUM_CH consumer channels (PE weight or image buffers).
- Unlike the single-shot prefetcher, it bounds outstanding reads by ROB depth, so bursts longer than the buffer stream continuously.

---
 rtl/prefetch_rob_mc.sv | 133 +++++++++++++
 tb/tb_prefetch_rob_mc.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_rob_mc.sv
// prefetch_rob_mc: windowed burst prefetcher with reorder buffer and in-order, channel-steered line output
module prefetch_rob_mc #(
  parameter int DATA_WIDTH  = 512,
  parameter int ROB_DEPTH   = 64,
  parameter int TAG_WIDTH   = 16,
  parameter int LINES_WIDTH = 16,
  parameter int ADDR_WIDTH  = 58,
  parameter int NUM_CH      = 4
) (
  input  logic                       clk,
  input  logic                       resetb,
  input  logic                       enable,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  input  logic [LINES_WIDTH-1:0]     num_lines,
  input  logic                       ch_mode,
  input  logic [$clog2(NUM_CH)-1:0]  ch_sel,
  output logic                       start_ack,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_req_valid,
  output logic [ADDR_WIDTH-1:0]      rd_req_addr,
  output logic [TAG_WIDTH-1:0]       rd_req_tag,
  input  logic                       rd_req_almostfull,
  input  logic                       rsp_valid,
  input  logic [TAG_WIDTH-1:0]       rsp_tag,
  input  logic [DATA_WIDTH-1:0]      rsp_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [NUM_CH-1:0]          out_ch,
  output logic [LINES_WIDTH-1:0]     out_index,
  output logic                       out_last,
  output logic                       err_dup
);
  localparam int RW = $clog2(ROB_DEPTH);
  localparam int CW = $clog2(NUM_CH);
  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} state_t;
  state_t state, state_nx;
  logic                   run;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [LINES_WIDTH-1:0] num_q, issue_idx, drain_idx, inflight;
  logic                   mode_q, af_q;
  logic [CW-1:0]          sel_q;
  logic [ROB_DEPTH-1:0]   valid, set_m, clr_m;
  logic [DATA_WIDTH-1:0]  mem [ROB_DEPTH];
  logic [RW-1:0]          head, slot;
  logic [NUM_CH-1:0]      ch_nx;
  logic                   rsp_acc, wr, load, pop, can_issue;
  assign run = resetb & enable;
  // datapath strobes, window check and next-state decode
  always_comb begin
    head      = drain_idx[RW-1:0];
    slot      = rsp_tag[RW-1:0];
    inflight  = issue_idx - drain_idx;
    rsp_acc   = rsp_valid && (state == ISSUE || state == FLUSH);
    wr        = rsp_acc && !valid[slot];
    pop       = out_valid && out_ready;
    load      = valid[head] && (!out_valid || out_ready);
    can_issue = state == ISSUE && issue_idx < num_q && !af_q && inflight < LINES_WIDTH'(ROB_DEPTH);
    set_m     = wr ? ROB_DEPTH'(1) << slot : '0;
    clr_m     = load ? ROB_DEPTH'(1) << head : '0;
    ch_nx     = mode_q ? NUM_CH'(1) << sel_q : NUM_CH'(1) << drain_idx[CW-1:0];
    start_ack = run && state == IDLE && start;
    busy      = state != IDLE;
    done      = state == DONE;
    state_nx  = state;
    case (state)
      IDLE:  state_nx = start ? (num_lines == '0 ? DONE : ISSUE) : IDLE;
      ISSUE: state_nx = issue_idx == num_q ? FLUSH : ISSUE;
      FLUSH: state_nx = pop && out_last ? DONE : FLUSH;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state register; dropping enable aborts straight to IDLE
  always_ff @(posedge clk) begin
    if (!run) state <= IDLE;
    else state <= state_nx;
  end
  // job capture, request issue, slot valid tracking and the output register
  always_ff @(posedge clk) begin
    if (!run) begin
      base_q       <= '0;
      num_q        <= '0;
      mode_q       <= 1'b0;
      sel_q        <= '0;
      af_q         <= 1'b0;
      issue_idx    <= '0;
      drain_idx    <= '0;
      valid        <= '0;
      err_dup      <= 1'b0;
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_tag   <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_ch       <= '0;
      out_index    <= '0;
      out_last     <= 1'b0;
    end else begin
      af_q         <= rd_req_almostfull;
      rd_req_valid <= can_issue;
      if (can_issue) begin
        rd_req_addr <= base_q + ADDR_WIDTH'(issue_idx);
        rd_req_tag  <= TAG_WIDTH'(issue_idx);
        issue_idx   <= issue_idx + 1'b1;
      end
      valid <= (valid & ~clr_m) | set_m;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= mem[head];
        out_ch    <= ch_nx;
        out_index <= drain_idx;
        out_last  <= drain_idx == num_q - 1'b1;
        drain_idx <= drain_idx + 1'b1;
      end else if (pop) out_valid <= 1'b0;
      if (start_ack) begin
        base_q    <= base_addr;
        num_q     <= num_lines;
        mode_q    <= ch_mode;
        sel_q     <= ch_sel;
        issue_idx <= '0;
        drain_idx <= '0;
        err_dup   <= 1'b0;
      end else if (rsp_acc && valid[slot]) err_dup <= 1'b1;
    end
  end
  // response data into its slot; storage content needs no reset since valid bits gate it
  always_ff @(posedge clk) begin
    if (run && wr) mem[slot] <= rsp_data;
  end
endmodule

// File: tb/tb_prefetch_rob_mc.sv
// tb_prefetch_rob_mc: directed scenario bench for the reorder-buffer prefetcher
module tb_prefetch_rob_mc;
  localparam int DW = 32, RD = 8, TW = 16, LW = 16, AW = 20, NC = 4;
  logic clk = 0, resetb = 0, enable = 0, start = 0, ch_mode = 0;
  logic rd_req_almostfull = 0, rsp_valid = 0, out_ready = 0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] num_lines = '0;
  logic [1:0]    ch_sel = '0;
  logic [TW-1:0] rsp_tag = '0;
  logic [DW-1:0] rsp_data = '0;
  logic start_ack, busy, done, rd_req_valid, out_valid, out_last, err_dup;
  logic [AW-1:0] rd_req_addr;
  logic [TW-1:0] rd_req_tag;
  logic [DW-1:0] out_data;
  logic [NC-1:0] out_ch;
  logic [LW-1:0] out_index;
  int checks = 0, errs = 0, cyc = 0;
  logic sack_seen;
  bit auto_rsp = 0;
  logic [TW-1:0] req_tag[$];
  logic [AW-1:0] req_addr[$];
  logic [LW-1:0] o_idx[$];
  logic [DW-1:0] o_dat[$];
  logic [NC-1:0] o_ch[$];
  logic          o_last[$];
  int req_cyc[$], o_cyc[$], ov_cyc[$], done_cyc[$], tag0_cyc[$], rsp_q[$];

  prefetch_rob_mc #(.DATA_WIDTH(DW), .ROB_DEPTH(RD), .TAG_WIDTH(TW), .LINES_WIDTH(LW),
                    .ADDR_WIDTH(AW), .NUM_CH(NC)) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .start(start), .base_addr(base_addr),
    .num_lines(num_lines), .ch_mode(ch_mode), .ch_sel(ch_sel), .start_ack(start_ack),
    .busy(busy), .done(done), .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
    .rd_req_tag(rd_req_tag), .rd_req_almostfull(rd_req_almostfull), .rsp_valid(rsp_valid),
    .rsp_tag(rsp_tag), .rsp_data(rsp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .out_index(out_index), .out_last(out_last),
    .err_dup(err_dup));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] fdat(int t);
    return 32'hA500_0000 + 32'(t);
  endfunction

  // passive logging on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rd_req_valid) begin
      req_tag.push_back(rd_req_tag);
      req_addr.push_back(rd_req_addr);
      req_cyc.push_back(cyc);
      if (auto_rsp) rsp_q.push_back(int'(rd_req_tag));
    end
    if (out_valid && out_ready) begin
      o_idx.push_back(out_index);
      o_dat.push_back(out_data);
      o_ch.push_back(out_ch);
      o_last.push_back(out_last);
      o_cyc.push_back(cyc);
    end
    if (out_valid) ov_cyc.push_back(cyc);
    if (done) done_cyc.push_back(cyc);
  end

  // memory model: one queued response per cycle; entries >= 256 are duplicates with corrupted data
  initial forever begin : resp
    int e;
    @(posedge clk); #1;
    if (rsp_q.size() > 0) begin
      e = rsp_q.pop_front();
      rsp_valid = 1;
      rsp_tag = TW'(e % 256);
      rsp_data = e >= 256 ? ~fdat(e - 256) : fdat(e);
      if (e == 0) tag0_cyc.push_back(cyc);
    end else rsp_valid = 0;
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs();
    req_tag.delete(); req_addr.delete(); req_cyc.delete(); o_idx.delete(); o_dat.delete();
    o_ch.delete(); o_last.delete(); o_cyc.delete(); ov_cyc.delete(); done_cyc.delete();
    tag0_cyc.delete(); rsp_q.delete();
  endtask

  task automatic start_job(int base, int n, bit mode, int sel);
    base_addr = AW'(base); num_lines = LW'(n); ch_mode = mode; ch_sel = 2'(sel); start = 1;
    #1 sack_seen = start_ack;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(int budget);
    for (int i = 0; i < budget && done_cyc.size() == 0; i++) tick();
    tick(2);
  endtask

  task automatic wait_reqs(int n, int budget);
    for (int i = 0; i < budget && req_tag.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    resetb = 0; enable = 1;
    tick(3);
    checks++;
    if ({start_ack, busy, done, rd_req_valid, out_valid, out_last, err_dup} !== 7'b0) begin
      errs++; $display("FAIL reset_flags: got %b want 0000000", {start_ack, busy, done, rd_req_valid, out_valid, out_last, err_dup});
    end
    checks++;
    if ({out_data, out_index, out_ch, rd_req_addr, rd_req_tag} !== '0) begin
      errs++; $display("FAIL reset_buses: data %0h idx %0h ch %0h addr %0h tag %0h want all 0", out_data, out_index, out_ch, rd_req_addr, rd_req_tag);
    end
    resetb = 1;
    tick();
  endtask

  task automatic test_in_order();
    clear_logs(); auto_rsp = 1; out_ready = 1;
    start_job(32'h100, 8, 0, 0);
    checks++;
    if (sack_seen !== 1'b1) begin errs++; $display("FAIL in_order_ack: got %b want 1", sack_seen); end
    wait_done(200);
    checks++;
    if (req_tag.size() != 8) begin errs++; $display("FAIL in_order_reqs: got %0d want 8", req_tag.size()); end
    for (int i = 0; i < req_tag.size(); i++) begin
      checks++;
      if (req_tag[i] !== TW'(i) || req_addr[i] !== AW'(32'h100 + i)) begin
        errs++; $display("FAIL in_order_req%0d: tag %0h addr %0h want tag %0h addr %0h", i, req_tag[i], req_addr[i], i, 32'h100 + i);
      end
    end
    checks++;
    if (o_idx.size() != 8) begin errs++; $display("FAIL in_order_lines: got %0d want 8", o_idx.size()); end
    for (int i = 0; i < o_idx.size(); i++) begin
      checks++;
      if (o_idx[i] !== LW'(i) || o_dat[i] !== fdat(i) || o_ch[i] !== NC'(1 << (i % 4)) || o_last[i] !== (i == 7)) begin
        errs++; $display("FAIL in_order_out%0d: idx %0h data %0h ch %b last %b want idx %0h data %0h ch %b last %b", i, o_idx[i], o_dat[i], o_ch[i], o_last[i], i, fdat(i), NC'(1 << (i % 4)), i == 7);
      end
    end
    checks++;
    if (done_cyc.size() != 1 || o_cyc.size() != 8 || done_cyc[0] != o_cyc[7] + 1) begin
      errs++; $display("FAIL in_order_done: got %0d pulses want 1 pulse one cycle after last line", done_cyc.size());
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL in_order_idle: busy %b done %b want 0 0", busy, done); end
  endtask

  task automatic test_out_of_order_dup();
    int seq [9] = '{7, 3, 259, 0, 1, 2, 6, 5, 4};
    clear_logs(); auto_rsp = 0; out_ready = 1;
    start_job(32'h200, 8, 0, 0);
    wait_reqs(8, 50);
    checks++;
    if (req_tag.size() != 8) begin errs++; $display("FAIL ooo_reqs: got %0d want 8", req_tag.size()); end
    foreach (seq[j]) rsp_q.push_back(seq[j]);
    wait_done(100);
    checks++;
    if (err_dup !== 1'b1) begin errs++; $display("FAIL ooo_err_dup: got %b want 1", err_dup); end
    checks++;
    if (o_idx.size() != 8) begin errs++; $display("FAIL ooo_lines: got %0d want 8", o_idx.size()); end
    for (int i = 0; i < o_idx.size(); i++) begin
      checks++;
      if (o_idx[i] !== LW'(i) || o_dat[i] !== fdat(i)) begin
        errs++; $display("FAIL ooo_out%0d: idx %0h data %0h want idx %0h data %0h", i, o_idx[i], o_dat[i], i, fdat(i));
      end
    end
    checks++;
    if (tag0_cyc.size() != 1 || ov_cyc.size() == 0 || ov_cyc[0] != tag0_cyc[0] + 2) begin
      errs++; $display("FAIL ooo_latency: first out_valid cycle %0d want tag0 cycle %0d + 2", ov_cyc.size() > 0 ? ov_cyc[0] : -1, tag0_cyc.size() > 0 ? tag0_cyc[0] : -1);
    end
  endtask

  task automatic test_window_single();
    clear_logs(); auto_rsp = 0; out_ready = 0;
    start_job(32'h300, 20, 1, 2);
    tick(20);
    checks++;
    if (req_tag.size() != RD) begin errs++; $display("FAIL window_stall: got %0d requests want %0d", req_tag.size(), RD); end
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || err_dup !== 1'b0) begin
      errs++; $display("FAIL window_state: busy %b out_valid %b err_dup %b want 1 0 0", busy, out_valid, err_dup);
    end
    auto_rsp = 1;
    for (int j = 0; j < RD; j++) rsp_q.push_back(j);
    out_ready = 1;
    wait_done(300);
    checks++;
    if (req_tag.size() != 20 || o_idx.size() != 20) begin
      errs++; $display("FAIL window_counts: reqs %0d lines %0d want 20 20", req_tag.size(), o_idx.size());
    end
    for (int i = 0; i < req_tag.size(); i++) begin
      checks++;
      if (req_tag[i] !== TW'(i) || req_addr[i] !== AW'(32'h300 + i)) begin
        errs++; $display("FAIL window_req%0d: tag %0h addr %0h want tag %0h addr %0h", i, req_tag[i], req_addr[i], i, 32'h300 + i);
      end
    end
    for (int i = 0; i < o_idx.size(); i++) begin
      checks++;
      if (o_idx[i] !== LW'(i) || o_dat[i] !== fdat(i) || o_ch[i] !== 4'b0100 || o_last[i] !== (i == 19)) begin
        errs++; $display("FAIL window_out%0d: idx %0h data %0h ch %b last %b want idx %0h data %0h ch 0100 last %b", i, o_idx[i], o_dat[i], o_ch[i], o_last[i], i, fdat(i), i == 19);
      end
    end
  endtask

  task automatic test_almostfull();
    int k, bad, resumed;
    clear_logs(); auto_rsp = 1; out_ready = 1;
    start_job(32'h400, 16, 0, 0);
    wait_reqs(3, 50);
    k = cyc;
    rd_req_almostfull = 1;
    tick(5);
    rd_req_almostfull = 0;
    wait_done(200);
    bad = 0; resumed = 0;
    foreach (req_cyc[j]) begin
      if (req_cyc[j] >= k + 2 && req_cyc[j] <= k + 6) bad++;
      if (req_cyc[j] == k + 7) resumed = 1;
    end
    checks++;
    if (bad != 0) begin errs++; $display("FAIL af_gap: got %0d requests inside blocked window want 0", bad); end
    checks++;
    if (resumed != 1) begin errs++; $display("FAIL af_resume: got %0d want request 2 cycles after fall", resumed); end
    checks++;
    if (req_tag.size() != 16 || o_idx.size() != 16) begin
      errs++; $display("FAIL af_counts: reqs %0d lines %0d want 16 16", req_tag.size(), o_idx.size());
    end
    for (int i = 0; i < o_idx.size(); i++) begin
      checks++;
      if (o_idx[i] !== LW'(i) || o_dat[i] !== fdat(i) || o_ch[i] !== NC'(1 << (i % 4))) begin
        errs++; $display("FAIL af_out%0d: idx %0h data %0h ch %b want idx %0h data %0h ch %b", i, o_idx[i], o_dat[i], o_ch[i], i, fdat(i), NC'(1 << (i % 4)));
      end
    end
  endtask

  task automatic test_abort();
    clear_logs(); auto_rsp = 0; out_ready = 0;
    start_job(32'h500, 8, 0, 0);
    wait_reqs(8, 50);
    tick(2);
    rsp_q.push_back(0);
    tick(4);
    checks++;
    if (out_valid !== 1'b1 || out_index !== '0 || busy !== 1'b1) begin
      errs++; $display("FAIL abort_pre: out_valid %b idx %0h busy %b want 1 0 1", out_valid, out_index, busy);
    end
    enable = 0;
    tick();
    checks++;
    if ({busy, out_valid, rd_req_valid, done} !== 4'b0 || out_data !== '0) begin
      errs++; $display("FAIL abort_idle: busy %b out_valid %b req %b done %b data %0h want all 0", busy, out_valid, rd_req_valid, done, out_data);
    end
    enable = 1;
    rsp_q.push_back(1); rsp_q.push_back(2);
    tick(5);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || err_dup !== 1'b0) begin
      errs++; $display("FAIL abort_late_rsp: out_valid %b busy %b err_dup %b want 0 0 0", out_valid, busy, err_dup);
    end
    clear_logs();
    start_job(32'h600, 0, 0, 0);
    checks++;
    if (sack_seen !== 1'b1) begin errs++; $display("FAIL zero_ack: got %b want 1", sack_seen); end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin errs++; $display("FAIL zero_done: done %b busy %b want 1 1", done, busy); end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL zero_idle: done %b busy %b want 0 0", done, busy); end
    tick(5);
    checks++;
    if (req_tag.size() != 0 || done_cyc.size() != 1) begin
      errs++; $display("FAIL zero_reqs: reqs %0d done pulses %0d want 0 1", req_tag.size(), done_cyc.size());
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_out_of_order_dup();
    test_window_single();
    test_almostfull();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
